sdp_ram_be_pipe: RTL and testbench

SDP_RAM_BE_PIPE -- requirements
Module: sdp_ram_be_pipe

---
 rtl/sdp_ram_be_pipe.sv | 138 +++++++++++++
 tb/tb_sdp_ram_be_pipe.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sdp_ram_be_pipe.sv
// sdp_ram_be_pipe: simple dual-port RAM with byte-lane writes and a
// configurable read pipeline (0, 1 or 2 cycles). After reset an optional
// sweep zeroes the whole array. Accesses are ignored while it runs.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   wr_en      write strobe
//   wr_addr    write address (AW bits)
//   wr_be      byte enables, bit i covers wr_data[8i+7:8i]
//   wr_data    write data (DW bits)
//   rd_en      read strobe
//   rd_addr    read address (AW bits)
//   rd_data    read data (DW bits)
//   rd_valid   rd_data carries the result of an accepted read
//   init_busy  clear sweep in progress
module sdp_ram_be_pipe #(
   parameter int unsigned DW         = 32,
   parameter int unsigned WORDS      = 256,
   parameter int unsigned RD_LAT     = 1,
   parameter int unsigned RDW_NEW    = 0,
   parameter int unsigned CLR_ON_RST = 1,
   localparam int unsigned AW        = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DW/8-1:0]   wr_be,
   input  logic [DW-1:0]     wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DW-1:0]     rd_data,
   output logic              rd_valid,
   output logic              init_busy
);

   localparam int unsigned   NB    = DW / 8;
   localparam logic [AW:0]   DEPTH = (AW + 1)'(WORDS);
   localparam logic [AW-1:0] LAST  = AW'(WORDS - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   logic [DW-1:0] mem [WORDS];

   logic          wr_in_range, rd_in_range;
   logic          wr_ok, rd_acc;
   logic [DW-1:0] wr_old, wr_word;
   logic [DW-1:0] rd_word, rd_pipe_word;

   logic          v1_q, v2_q;
   logic [DW-1:0] d1_q, d2_q;

   assign init_busy   = (state_q == CLEAR);
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH);
   assign wr_ok       = wr_en && !init_busy && wr_in_range;
   assign rd_acc      = rd_en && !init_busy;

   // Init FSM: sweep counter walks 0..WORDS-1, then READY.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            state_d = READY;
            cnt_d   = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= (CLR_ON_RST != 0) ? CLEAR : READY;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Merged write word: enabled lanes from wr_data, others from the array.
   always_comb begin
      wr_old = '0;
      if (wr_in_range)
         wr_old = mem[wr_addr];
      wr_word = wr_old;
      for (int unsigned i = 0; i < NB; i++)
         if (wr_be[i])
            wr_word[8*i +: 8] = wr_data[8*i +: 8];
   end

   // Out-of-range reads return zero; a colliding write only forwards when
   // new-data read-during-write is selected.
   always_comb begin
      rd_word = '0;
      if (rd_in_range)
         rd_word = mem[rd_addr];
      rd_pipe_word = rd_word;
      if (RDW_NEW != 0 && wr_ok && wr_addr == rd_addr)
         rd_pipe_word = wr_word;
   end

   // Single write port shared by the clear sweep and user writes.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (init_busy)
            mem[cnt_q] <= '0;
         else if (wr_ok)
            mem[wr_addr] <= wr_word;
      end
   end

   // Read pipeline; data registers hold while no read is flowing.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         d1_q <= '0;
         d2_q <= '0;
      end else begin
         v1_q <= rd_acc;
         v2_q <= v1_q;
         if (rd_acc)
            d1_q <= rd_pipe_word;
         if (v1_q)
            d2_q <= d1_q;
      end
   end

   assign rd_data  = (RD_LAT == 0) ? rd_word : (RD_LAT == 1) ? d1_q : d2_q;
   assign rd_valid = (RD_LAT == 0) ? rd_acc  : (RD_LAT == 1) ? v1_q : v2_q;

endmodule

// File: tb/tb_sdp_ram_be_pipe.sv
// Directed bench for sdp_ram_be_pipe. Five instances share one input bus:
//   u0 RD_LAT=0, u1 RD_LAT=1 RDW_NEW=1, u2 RD_LAT=2,
//   u3 WORDS=12 RD_LAT=1 (out-of-range addresses), u4 CLR_ON_RST=0 RD_LAT=1.
module tb_sdp_ram_be_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [3:0]  wr_be;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [3:0]  rd_addr;

   logic [31:0] d0, d1, d2, d3, d4;
   logic        v0, v1, v2, v3, v4;
   logic        b0, b1, b2, b3, b4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sdp_ram_be_pipe #(.DW(32), .WORDS(16), .RD_LAT(0), .RDW_NEW(0), .CLR_ON_RST(1)) u0 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(d0), .rd_valid(v0), .init_busy(b0));
   sdp_ram_be_pipe #(.DW(32), .WORDS(16), .RD_LAT(1), .RDW_NEW(1), .CLR_ON_RST(1)) u1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(d1), .rd_valid(v1), .init_busy(b1));
   sdp_ram_be_pipe #(.DW(32), .WORDS(16), .RD_LAT(2), .RDW_NEW(0), .CLR_ON_RST(1)) u2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(d2), .rd_valid(v2), .init_busy(b2));
   sdp_ram_be_pipe #(.DW(32), .WORDS(12), .RD_LAT(1), .RDW_NEW(0), .CLR_ON_RST(1)) u3 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(d3), .rd_valid(v3), .init_busy(b3));
   sdp_ram_be_pipe #(.DW(32), .WORDS(16), .RD_LAT(1), .RDW_NEW(0), .CLR_ON_RST(0)) u4 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
      .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(d4), .rd_valid(v4), .init_busy(b4));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Walks the clear sweep, counting busy cycles of u0 and u3 and any
   // rd_valid seen. With access=1 the first 10 sweep cycles also carry a
   // write of 5 to addr 3 and a read of addr 3.
   task automatic sweep_count(input bit access, output int n0, output int n3, output int vs);
      n0 = 0;
      n3 = 0;
      vs = 0;
      while (b0 && n0 < 40) begin
         n0++;
         if (b3) n3++;
         if (access && n0 <= 10) begin
            wr_en = 1'b1; wr_addr = 4'd3; wr_be = 4'hf; wr_data = 32'h5;
            rd_en = 1'b1; rd_addr = 4'd3;
         end else begin
            wr_en = 1'b0;
            rd_en = 1'b0;
         end
         #1;
         if (v0 | v1 | v2 | v3) vs++;
         tick();
      end
      wr_en = 1'b0;
      rd_en = 1'b0;
   endtask

   initial begin
      int n0, n3, vs;
      logic [31:0] e;

      rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_be = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr = '0;
      tick();

      // Reset state
      check("rst_busy_u0", b0, 1);
      check("rst_busy_u4", b4, 0);
      check("rst_v1", v1, 0);
      check("rst_v2", v2, 0);
      check("rst_v3", v3, 0);
      check("rst_d1", d1, 0);
      check("rst_d2", d2, 0);
      check("rst_d3", d3, 0);
      check("rst_d4", d4, 0);
      rst = 1'b0;

      // Sweep with ignored accesses
      sweep_count(1'b1, n0, n3, vs);
      check("sweep_len16", n0, 16);
      check("sweep_len12", n3, 12);
      check("sweep_no_valid", vs, 0);
      check("ready_u1", b1, 0);

      // Every address reads zero; u4 did accept the write to addr 3
      for (int a = 0; a < 16; a++) begin
         rd_en = 1'b1; rd_addr = 4'(a);
         #1;
         check("clr_v0", v0, 1);
         check("clr_d0", d0, 0);
         tick();
         check("clr_v1", v1, 1);
         check("clr_d1", d1, 0);
         if (a == 3) check("noclr_u4_a3", d4, 32'h5);
      end
      rd_en = 1'b0;

      // Byte enables
      wr_en = 1'b1; wr_addr = 4'd5; wr_be = 4'hf; wr_data = 32'hAABBCCDD;
      tick();
      wr_be = 4'h5; wr_data = 32'h11223344;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b1; rd_addr = 4'd5;
      #1;
      check("be_d0", d0, 32'hAA22CC44);
      tick();
      rd_en = 1'b0;
      check("be_v1", v1, 1);
      check("be_d1", d1, 32'hAA22CC44);
      check("be_d4", d4, 32'hAA22CC44);

      // Latency: back-to-back reads of 1,2,3
      for (int k = 1; k <= 3; k++) begin
         wr_en = 1'b1; wr_addr = 4'(k); wr_be = 4'hf; wr_data = 32'(16 * k);
         tick();
      end
      wr_en = 1'b0;
      for (int c = 0; c < 5; c++) begin
         rd_en = (c < 3); rd_addr = 4'(c + 1);
         #1;
         check("lat0_v", v0, (c < 3) ? 1 : 0);
         if (c < 3) check("lat0_d", d0, 32'(16 * (c + 1)));
         tick();
         check("lat1_v", v1, (c < 3) ? 1 : 0);
         check("lat1_d", d1, (c < 3) ? 32'(16 * (c + 1)) : 32'h30);
         check("lat2_v", v2, (c >= 1 && c < 4) ? 1 : 0);
         e = (c == 0) ? 32'hAA22CC44 : (c <= 3) ? 32'(16 * c) : 32'h30;
         check("lat2_d", d2, e);
      end
      rd_en = 1'b0;

      // Read-during-write collision on addr 7
      wr_en = 1'b1; wr_addr = 4'd7; wr_be = 4'h3; wr_data = 32'hFFFFFFFF;
      rd_en = 1'b1; rd_addr = 4'd7;
      #1;
      check("rdw_d0_old", d0, 0);
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      check("rdw_v1", v1, 1);
      check("rdw_new_d1", d1, 32'h0000FFFF);
      check("rdw_old_d3", d3, 0);
      #1;
      check("rdw_d0_after", d0, 32'h0000FFFF);
      tick();
      check("rdw_v2", v2, 1);
      check("rdw_old_d2", d2, 0);

      // Address beyond depth on the 12-word instance
      wr_en = 1'b1; wr_addr = 4'd13; wr_be = 4'hf; wr_data = 32'hDEADBEEF;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b1; rd_addr = 4'd13;
      #1;
      check("wrap_d0", d0, 32'hDEADBEEF);
      tick();
      rd_en = 1'b0;
      check("wrap_v3", v3, 1);
      check("wrap_d3", d3, 0);
      check("wrap_d1", d1, 32'hDEADBEEF);

      // Reset with a read in flight
      rd_en = 1'b1; rd_addr = 4'd1;
      tick();
      rd_en = 1'b0; rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_v2", v2, 0);
      check("mid_d2", d2, 0);
      check("mid_d1", d1, 0);
      check("mid_busy_u2", b2, 1);
      check("mid_busy_u4", b4, 0);
      sweep_count(1'b0, n0, n3, vs);
      check("resweep_len16", n0, 16);
      check("resweep_len12", n3, 12);
      check("resweep_no_valid", vs, 0);
      rd_en = 1'b1; rd_addr = 4'd5;
      #1;
      check("resweep_d0", d0, 0);
      tick();
      rd_en = 1'b0;
      check("resweep_d1", d1, 0);
      check("keep_d4", d4, 32'hAA22CC44);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
